// File: rtl/keyboard_accel_adapter_if.sv
// keyboard_accel_adapter_if: keyboard event lines and CPU accelerator read/write port
interface keyboard_accel_adapter_if #(
  parameter int SYMBOL_WIDTH = 7
);
  logic                    keyboard_left;
  logic                    keyboard_right;
  logic                    keyboard_backspace;
  logic [SYMBOL_WIDTH-1:0] keyboard_symbol;
  logic                    accel_can_read;
  logic                    accel_can_write;
  logic                    accel_read_enable;
  logic                    accel_write_enable;
  logic [15:0]             accel_read_data;
  logic [15:0]             accel_write_data;
  modport master (
    output keyboard_left, keyboard_right, keyboard_backspace, keyboard_symbol,
    output accel_read_enable, accel_write_enable, accel_write_data,
    input  accel_can_read, accel_can_write, accel_read_data
  );
  modport slave (
    input  keyboard_left, keyboard_right, keyboard_backspace, keyboard_symbol,
    input  accel_read_enable, accel_write_enable, accel_write_data,
    output accel_can_read, accel_can_write, accel_read_data
  );
endinterface

// File: rtl/keyboard_accel_adapter.sv
// keyboard_accel_adapter: FIFO of keyboard events exposed as a CPU accelerator read port
module keyboard_accel_adapter #(
  parameter int SYMBOL_WIDTH = 7,
  parameter int DEPTH        = 16
) (
  input logic clk,
  input logic rst,
  keyboard_accel_adapter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = SYMBOL_WIDTH + 4;
  logic [EW-1:0]           mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]             count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    ev_any, pop, push, drop, flush, full, empty;
  logic [2:0]              ev_type;
  logic [SYMBOL_WIDTH-1:0] ev_sym;
  logic [EW-1:0]           head;
  logic                    unused_wdata;
  assign unused_wdata = ^bus.accel_write_data[15:1];
  // select the single highest-priority event of this cycle
  always_comb begin
    ev_any  = bus.keyboard_backspace | bus.keyboard_left | bus.keyboard_right | (|bus.keyboard_symbol);
    ev_type = bus.keyboard_backspace ? 3'd4 : bus.keyboard_left ? 3'd2 : bus.keyboard_right ? 3'd3 : 3'd1;
    ev_sym  = (bus.keyboard_backspace | bus.keyboard_left | bus.keyboard_right) ? '0 : bus.keyboard_symbol;
  end
  // FIFO bookkeeping: a full FIFO still accepts a push when the head is popped this cycle
  always_comb begin
    empty    = count_q == '0;
    full     = count_q == (AW+1)'(DEPTH);
    flush    = bus.accel_write_enable & bus.accel_write_data[0];
    pop      = bus.accel_read_enable & ~empty;
    push     = ev_any & (~full | pop);
    drop     = ev_any & full & ~pop;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d  = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d    = flush ? 1'b0 : drop ? 1'b1 : push ? 1'b0 : ovf_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end
  // event storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (!rst && push && !flush) mem_q[wr_ptr_q] <= {ovf_q, ev_type, ev_sym};
  end
  // show-ahead head word, zero when empty
  always_comb begin
    head                 = mem_q[rd_ptr_q];
    bus.accel_can_read   = ~empty;
    bus.accel_can_write  = 1'b1;
    bus.accel_read_data  = empty ? 16'h0000 : {head[EW-1], {(12-SYMBOL_WIDTH){1'b0}}, head[EW-2:0]};
  end
endmodule

// File: tb/tb_keyboard_accel_adapter.sv
// tb_keyboard_accel_adapter: randomized and directed checks against a queue-based event model
module tb_keyboard_accel_adapter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  keyboard_accel_adapter_if #(.SYMBOL_WIDTH(7)) kif ();
  keyboard_accel_adapter #(.SYMBOL_WIDTH(7), .DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(kif.slave));
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] mq [$];
  logic        m_ovf = 1'b0;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic l, input logic r, input logic b, input logic [6:0] s,
                     input logic re, input logic we, input logic [15:0] wd, input logic rs);
    logic [2:0] typ;
    logic [6:0] code;
    kif.keyboard_left      = l;
    kif.keyboard_right     = r;
    kif.keyboard_backspace = b;
    kif.keyboard_symbol    = s;
    kif.accel_read_enable  = re;
    kif.accel_write_enable = we;
    kif.accel_write_data   = wd;
    rst                    = rs;
    check("can_read", {15'b0, kif.accel_can_read}, {15'b0, mq.size() != 0});
    check("read_data", kif.accel_read_data, mq.size() != 0 ? mq[0] : 16'h0000);
    check("can_write", {15'b0, kif.accel_can_write}, 16'h0001);
    @(posedge clk);
    if (rs || (we && wd[0])) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (re && mq.size() != 0) void'(mq.pop_front());
      if (b || l || r || s != 0) begin
        typ  = b ? 3'd4 : l ? 3'd2 : r ? 3'd3 : 3'd1;
        code = (typ == 3'd1) ? s : 7'd0;
        if (mq.size() < 16) begin
          mq.push_back({m_ovf, 5'b0, typ, code});
          m_ovf = 1'b0;
        end else m_ovf = 1'b1;
      end
    end
    @(negedge clk);
  endtask
  task automatic sym(input logic [6:0] s);
    cyc(0, 0, 0, s, 0, 0, 16'h0, 0);
  endtask
  task automatic pop1();
    cyc(0, 0, 0, 7'h0, 1, 0, 16'h0, 0);
  endtask
  initial begin
    kif.keyboard_left = 0; kif.keyboard_right = 0; kif.keyboard_backspace = 0;
    kif.keyboard_symbol = 0; kif.accel_read_enable = 0; kif.accel_write_enable = 0;
    kif.accel_write_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc(0, 0, 0, 7'h0, 0, 0, 16'h0, 0);
    sym(7'h41);
    check("t1_data", kif.accel_read_data, 16'h00C1);
    pop1();
    check("t1_empty", kif.accel_read_data, 16'h0000);
    cyc(1, 0, 0, 7'h31, 0, 0, 16'h0, 0);
    check("t2_left", kif.accel_read_data, 16'h0100);
    cyc(0, 1, 0, 7'h0, 0, 0, 16'h0, 0);
    cyc(0, 0, 1, 7'h0, 0, 0, 16'h0, 0);
    repeat (3) pop1();
    repeat (17) sym(7'h41);
    pop1();
    sym(7'h42);
    while (mq.size() > 1) pop1();
    check("t3_tail", kif.accel_read_data, 16'h80C2);
    pop1();
    repeat (16) sym(7'h41);
    cyc(0, 0, 0, 7'h43, 1, 0, 16'h0, 0);
    repeat (15) pop1();
    check("t4_tail", kif.accel_read_data, 16'h00C3);
    pop1();
    repeat (5) sym(7'h50);
    cyc(0, 0, 0, 7'h44, 1, 1, 16'h0001, 0);
    check("t5_flush", {15'b0, kif.accel_can_read}, 16'h0000);
    sym(7'h45);
    cyc(0, 0, 0, 7'h0, 0, 1, 16'hFFFE, 0);
    check("t5_noflush", kif.accel_read_data, 16'h00C5);
    pop1();
    pop1();
    repeat (3) sym(7'h46);
    cyc(0, 0, 0, 7'h47, 0, 0, 16'h0, 1);
    check("t6_rst", {15'b0, kif.accel_can_read}, 16'h0000);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 7'($urandom_range(1, 127)), $urandom_range(0, 1), 0, 16'h0, 0);
    for (int blk = 0; blk < 14; blk++) begin
      int pk = $urandom_range(5, 95);
      int pp = $urandom_range(5, 95);
      for (int i = 0; i < 60; i++) begin
        logic ev = $urandom_range(0, 99) < pk;
        cyc(ev && $urandom_range(0, 3) == 0, ev && $urandom_range(0, 3) == 0,
            ev && $urandom_range(0, 5) == 0, ev ? 7'($urandom_range(0, 127)) : 7'h0,
            $urandom_range(0, 99) < pp, $urandom_range(0, 99) < 3, 16'($urandom),
            $urandom_range(0, 199) == 0);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
